// File: rtl/qtcore_pkg.sv
// Shared types and defaults for the qtcore scan host: FSM state encoding,
// default chain length and run-phase limit.
package qtcore_pkg;

  localparam int unsigned QTCORE_CHAIN_LEN = 144;
  localparam int unsigned QTCORE_RUN_MAX   = 4095;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    PUSH,
    RUN,
    FIN
  } scan_host_state_t;

  function automatic int unsigned chain_bytes(input int unsigned len);
    return len / 8;
  endfunction

endpackage

// File: rtl/qtcore_scan_shifter.sv
// Byte-wide shift register plus bit counter: loads an image byte, shifts it out
// MSB-first while capturing the chain tail into the LSB.
module qtcore_scan_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] byte_in,
  input  logic       ser_in,
  output logic       ser_out,
  output logic [7:0] byte_out,
  output logic       last_bit
);

  logic [7:0] sr_q;
  logic [2:0] bit_q;

  // NOTE: non-blocking assignments, so every flop updates from pre-edge values
  // regardless of statement order or of other blocks on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      bit_q <= '0;
    end else if (load) begin
      sr_q  <= byte_in;
      bit_q <= '0;
    end else if (shift) begin
      sr_q  <= {sr_q[6:0], ser_in};
      bit_q <= bit_q + 3'd1;
    end
  end

  assign ser_out  = sr_q[7];
  assign byte_out = sr_q;
  assign last_bit = (bit_q == 3'd7);

endmodule

// File: rtl/qtcore_scan_host.sv
// Host driver for the qtcore scan port: streams CHAIN_LEN bits in/out a byte at a
// time. Define QTCORE_SCAN_HOST_RUN_EN to add the run-until-halt phase.
module qtcore_scan_host
  import qtcore_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = QTCORE_CHAIN_LEN,
  parameter int unsigned RUN_MAX   = QTCORE_RUN_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run_req,
  output logic        busy,
  output logic        done,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        scan_en_n,
  output logic        scan_in_o,
  input  logic        scan_out_i,
  output logic        proc_en_n,
  input  logic        halt_i,
  output logic [15:0] run_cycles,
  output logic        timeout
);

  localparam int unsigned NBYTES = chain_bytes(CHAIN_LEN);
  localparam int unsigned BCW    = (NBYTES < 1) ? 1 : $clog2(NBYTES + 1);

  if (CHAIN_LEN == 0 || (CHAIN_LEN % 8) != 0) begin : g_bad_chain_len
    $error("qtcore_scan_host: CHAIN_LEN (%0d) must be a non-zero multiple of 8", CHAIN_LEN);
  end

  scan_host_state_t state_q, state_d;
  logic [BCW-1:0]   bytes_q, bytes_d;
  logic busy_q, done_q, in_ready_q, out_valid_q, scan_en_n_q;
  logic load, shift, last_bit;
  logic [7:0] byte_out;
  logic run_go;     // pass continues into RUN instead of FIN
  logic run_leave;  // RUN has dropped proc_en_n and may finish

  qtcore_scan_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .byte_in  (in_data),
    .ser_in   (scan_out_i),
    .ser_out  (scan_in_o),
    .byte_out (byte_out),
    .last_bit (last_bit)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bytes_d = bytes_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        bytes_d = BCW'(NBYTES);
      end
      FETCH: if (in_valid && in_ready_q) begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) state_d = PUSH;
      end
      PUSH: if (out_ready) begin
        bytes_d = bytes_q - BCW'(1);
        if (bytes_q == BCW'(1)) state_d = run_go ? RUN : FIN;
        else                    state_d = FETCH;
      end
      RUN:     if (run_leave) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and scan outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bytes_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      scan_en_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bytes_q     <= bytes_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == FIN);
      in_ready_q  <= (state_d == FETCH);
      out_valid_q <= (state_d == PUSH);
      scan_en_n_q <= (state_d != SHIFT);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = byte_out;
  assign scan_en_n = scan_en_n_q;

`ifdef QTCORE_SCAN_HOST_RUN_EN
  logic        run_flag_q, proc_en_n_q, timeout_q;
  logic [15:0] run_cycles_q, run_cycles_inc;
  logic        running, at_max;

  // proc_en_n rises one cycle before RUN hands over to FIN, so done trails it by a cycle.
  assign running        = (state_q == RUN) && !proc_en_n_q;
  assign run_cycles_inc = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
  assign at_max         = (run_cycles_inc == 16'(RUN_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_flag_q   <= 1'b0;
      proc_en_n_q  <= 1'b1;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        run_flag_q   <= run_req;
        run_cycles_q <= '0;
        timeout_q    <= 1'b0;
      end
      if (state_q == PUSH && state_d == RUN) proc_en_n_q <= 1'b0;
      else if (running && (halt_i || at_max)) proc_en_n_q <= 1'b1;
      if (running) begin
        run_cycles_q <= run_cycles_inc;
        if (at_max) timeout_q <= 1'b1;
      end
    end
  end

  assign run_go     = run_flag_q;
  assign run_leave  = proc_en_n_q;
  assign proc_en_n  = proc_en_n_q;
  assign run_cycles = run_cycles_q;
  assign timeout    = timeout_q;
`else
  logic unused_run;
  assign unused_run = run_req ^ halt_i;
  assign run_go     = 1'b0;
  assign run_leave  = 1'b1;
  assign proc_en_n  = 1'b1;
  assign run_cycles = '0;
  assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_qtcore_scan_host.sv
// Self-checking bench for qtcore_scan_host with a 16-bit behavioural scan chain
// and a halt model; expectations adapt to QTCORE_SCAN_HOST_RUN_EN.
module tb_qtcore_scan_host;

  localparam int CL     = 16;
  localparam int NB     = CL / 8;
  localparam int RMAX   = 100;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, run_req, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        busy, done, in_ready, out_valid, scan_en_n, scan_in_o, proc_en_n, timeout;
  logic [7:0]  out_data;
  logic [15:0] run_cycles;
  logic        scan_out_i, halt_i;

  qtcore_scan_host #(.CHAIN_LEN(CL), .RUN_MAX(RMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run_req    (run_req),
    .busy       (busy),
    .done       (done),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .scan_en_n  (scan_en_n),
    .scan_in_o  (scan_in_o),
    .scan_out_i (scan_out_i),
    .proc_en_n  (proc_en_n),
    .halt_i     (halt_i),
    .run_cycles (run_cycles),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Core model: a plain CL-bit chain shifting toward the tail, plus a halt that
  // fires on the halt_cfg-th enabled cycle (0 = never halts).
  logic [CL-1:0] chain;
  logic          preload_en = 1'b0, pass_clr = 1'b0;
  logic [CL-1:0] preload_val = '0;
  int            shift_edges = 0, en_cnt = 0, halt_cfg = 0;
  int            both_low = 0, drops = 0;
  logic          pend = 1'b0;

  always @(posedge clk) begin
    if (preload_en) chain <= preload_val;
    else if (!scan_en_n) chain <= {chain[CL-2:0], scan_in_o};
    if (pass_clr) begin
      shift_edges <= 0;
      en_cnt      <= 0;
    end else begin
      if (!scan_en_n) shift_edges <= shift_edges + 1;
      if (!proc_en_n) en_cnt <= en_cnt + 1;
    end
    if (!scan_en_n && !proc_en_n) both_low <= both_low + 1;
    if (pend && !out_valid) drops <= drops + 1;
    pend <= out_valid && !out_ready && !rst;
  end

  assign scan_out_i = chain[CL-1];
  assign halt_i     = (halt_cfg != 0) && (en_cnt >= halt_cfg - 1);

  int n_checks = 0, n_errors = 0;
  logic [7:0] img [NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_scan_en_n",  32'(scan_en_n),  32'd1);
    check("rst_scan_in_o",  32'(scan_in_o),  32'd0);
    check("rst_proc_en_n",  32'(proc_en_n),  32'd1);
    check("rst_run_cycles", 32'(run_cycles), 32'd0);
    check("rst_timeout",    32'(timeout),    32'd0);
  endtask

  // One full load/readback pass with optional source/sink stalls and an extra
  // start pulse while busy; out bytes, final chain and run results are predicted
  // from the chain contents before the pass.
  task automatic do_pass(input bit do_preload, input logic [CL-1:0] pre_val, input bit want_run,
                         input int halt_at, input int in_gap_byte, input int in_gap_len,
                         input int out_gap_byte, input int out_gap_len, input int busy_start_at);
    logic [CL-1:0] prior, exp_chain;
    int fed, got, in_wait, out_wait, stall_bad, proc_low;
    int done_cyc, rise_cyc, last_out_cyc;
    bit in_gap, out_gap, acc_in, acc_out, prev_proc_n;
    preload_en  = do_preload;
    preload_val = pre_val;
    halt_cfg    = halt_at;
    pass_clr    = 1'b1;
    tick();
    preload_en = 1'b0;
    pass_clr   = 1'b0;
    prior      = chain;
    for (int i = 0; i < NB; i++) exp_chain[CL-1-8*i -: 8] = img[i];
    start   = 1'b1;
    run_req = want_run;
    tick();
    start   = 1'b0;
    run_req = 1'($urandom_range(0, 1));
    check("busy_after_start", 32'(busy), 32'd1);
    fed = 0; got = 0; in_wait = 0; out_wait = 0; stall_bad = 0; proc_low = 0;
    done_cyc = -1; rise_cyc = -1; last_out_cyc = -1; prev_proc_n = 1'b1;
    for (int cyc = 0; cyc < BUDGET && done_cyc < 0; cyc++) begin
      in_gap  = (fed == in_gap_byte) && (in_wait < in_gap_len);
      out_gap = (got == out_gap_byte) && (out_wait < out_gap_len);
      if (in_gap && in_ready) begin
        in_wait++;
        if (!scan_en_n) stall_bad++;
      end
      if (out_gap && out_valid) begin
        out_wait++;
        if (!scan_en_n) stall_bad++;
      end
      in_valid  = (fed < NB) && !in_gap;
      in_data   = (fed < NB) ? img[fed] : 8'($urandom);
      out_ready = !out_gap;
      start     = (cyc == busy_start_at);
      if (done) done_cyc = cyc;
      if (proc_en_n && !prev_proc_n) rise_cyc = cyc;
      if (!proc_en_n) proc_low++;
      prev_proc_n = proc_en_n;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        if (got < NB) check("out_byte", 32'(out_data), 32'(prior[CL-1-8*got -: 8]));
        last_out_cyc = cyc;
      end
      tick();
      if (acc_in) fed++;
      if (acc_out) got++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("done_seen",     32'(done_cyc >= 0), 32'd1);
    check("done_one_cyc",  32'(done),      32'd0);
    check("busy_end",      32'(busy),      32'd0);
    check("proc_en_n_end", 32'(proc_en_n), 32'd1);
    check("bytes_in",      32'(fed),       32'(NB));
    check("bytes_out",     32'(got),       32'(NB));
    check("shift_edges",   32'(shift_edges), 32'(CL));
    check("final_chain",   32'(chain),     32'(exp_chain));
    check("stall_scan_en", 32'(stall_bad), 32'd0);
`ifdef QTCORE_SCAN_HOST_RUN_EN
    if (want_run) begin
      check("run_cycles",      32'(run_cycles), (halt_at == 0) ? 32'(RMAX) : 32'(halt_at));
      check("timeout",         32'(timeout),    32'(halt_at == 0));
      check("proc_low_cycles", 32'(proc_low),   (halt_at == 0) ? 32'(RMAX) : 32'(halt_at));
      check("done_after_rise", 32'(done_cyc - rise_cyc), 32'd1);
    end else
`endif
    begin
      check("run_cycles_idle",  32'(run_cycles), 32'd0);
      check("timeout_idle",     32'(timeout),    32'd0);
      check("proc_low_cycles",  32'(proc_low),   32'd0);
      check("done_after_push",  32'(done_cyc - last_out_cyc), 32'd1);
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sh;
    rst = 1'b1; start = 1'b0; run_req = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    check_reset_values();
    rst = 1'b0;
    tick();

    // T1: directed image over a known chain.
    img[0] = 8'hA5; img[1] = 8'h3C;
    do_pass(1'b1, 16'hBEEF, 1'b0, 0, -1, 0, -1, 0, -1);

    // T2: source stalls 20 cycles on byte 1, sink stalls 5 cycles on byte 0.
    do_pass(1'b1, 16'h1234, 1'b0, 0, 1, 20, 0, 5, -1);

    // T3: start pulse mid-pass is ignored; then reset in the 7th SHIFT cycle.
    img[0] = 8'h69; img[1] = 8'hC3;
    do_pass(1'b1, 16'h0F0F, 1'b0, 0, -1, 0, -1, 0, 5);
    start = 1'b1; run_req = 1'b0;
    tick();
    start = 1'b0;
    sh = 0;
    for (int c = 0; c < 50; c++) begin
      if (!scan_en_n) sh++;
      if (sh == 7) break;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
    end
    check("reached_shift7", 32'(sh), 32'd7);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_values();
    rst = 1'b0;
    tick();
    img[0] = 8'hA5; img[1] = 8'h3C;
    do_pass(1'b0, '0, 1'b0, 0, -1, 0, -1, 0, -1);

    // T4/T5/T6: run phase with halt after 37 cycles, halt never, halt on entry.
    do_pass(1'b1, 16'h55AA, 1'b1, 37, -1, 0, -1, 0, -1);
    do_pass(1'b1, 16'hAA55, 1'b1, 0,  -1, 0, -1, 0, -1);
    do_pass(1'b1, 16'h8001, 1'b1, 1,  -1, 0, -1, 0, -1);
    do_pass(1'b1, 16'h7FFE, 1'b0, 5,  -1, 0, -1, 0, -1);

    // Randomised passes.
    for (int p = 0; p < 12; p++) begin
      int h;
      img[0] = 8'($urandom);
      img[1] = 8'($urandom);
      h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 60));
      do_pass(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), h,
              int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 12)));
    end

    check("never_both_low", 32'(both_low), 32'd0);
    check("valid_hold",     32'(drops),    32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
